apb_display_capture: RTL and testbench
======================================

// Module: apb_display_capture
// PURPOSE
// - Passive APB monitor feeding the 4-digit seven-segment display stage. Latches the last completed
//   transfer's address, write data and read data; holds them stable for the display.
// - Also debounces the front-panel button and produces the 2-bit display select (addr/wdata/rdata).
// - Sits between the APB bus (master/slave pins) and the display driver; never drives the bus.
// PARAMETERS
// - DEB_CYCLES  400000  clk cycles a synchronised button level must hold before it is accepted
// - CNT_W       16      width of completed-transfer counter xfer_count
// PORTS
// - clk          in   1   system clock, all logic rising-edge
// - rst_n        in   1   asynchronous active-low reset
// - psel         in   1   APB select (monitored)
// - penable      in   1   APB enable (monitored)
// - pwrite       in   1   APB direction, 1 = write
// - paddr        in   32  APB address
// - pwdata       in   32  APB write data
// - prdata       in   32  APB read data
// - pready       in   1   APB ready (slave)
// - btn          in   1   raw asynchronous front-panel button, active-high
// - freeze       in   1   hold captured values (used only when DISP_FREEZE_EN defined)
// - address      out  32  last completed transfer address -> display
// - data         out  32  last completed write data -> display
// - coming_data  out  32  last completed read data -> display
// - switch       out  2   display select: 00 addr, 01 wdata, 10 rdata; 11 never driven
// - xfer_count   out  CNT_W  number of completed transfers, wraps at 2^CNT_W
// - proto_err    out  1   sticky: APB protocol violation observed
// BEHAVIOUR
// - Reset (async assert, sync release): all outputs 0, FSM IDLE, debouncer stable level 0, counter 0.
// - FSM tracks bus phase: IDLE --psel&!penable--> SETUP --1 cycle--> ACCESS;
//   ACCESS stays while !pready; ACCESS --pready--> SETUP if psel&!penable same cycle... no: on pready,
//   next state = IDLE, or SETUP when next cycle samples psel&!penable (back-to-back, evaluated in IDLE).
// - Completion = state ACCESS & psel & penable & pready. On completion, registered next edge (1-cycle lat):
//   address<=paddr; pwrite ? data<=pwdata : coming_data<=prdata; xfer_count<=xfer_count+1 (wraps).
//   Unselected data register keeps its old value.
// - Wait states: no capture while pready=0; paddr/pwdata sampled only at completing cycle.
// - proto_err set (sticky until reset) when: penable=1 in IDLE; penable=0 in ACCESS with psel=1;
//   psel drops in ACCESS before pready. On violation FSM returns to IDLE, no capture.
// - Debounce: btn -> 2-FF synchroniser -> counter of $clog2(DEB_CYCLES+1) bits; reset to 0 whenever
//   sync level == accepted level; on reaching DEB_CYCLES accepted level toggles and counter clears.
// - Accepted-level rising edge advances switch 00->01->10->00 (one step per press). Release: no change.
// - Bounce shorter than DEB_CYCLES: no switch change. Press held indefinitely: exactly one step.
// - Completion and button step in same cycle: both take effect independently.
// - Reset mid-transfer: FSM IDLE, nothing captured; next transfer must start with a fresh SETUP.
// CONFIGURATION
// - `DISP_FREEZE_EN defined: while freeze=1, address/data/coming_data hold; xfer_count still counts;
//   freeze release does not replay missed transfers (next completion captured normally).
// - Not defined: freeze port present but ignored; capture always enabled.
// STRUCTURE
// - Package apb_disp_pkg: state enum {IDLE,SETUP,ACCESS}; select constants SEL_ADDR=2'b00,
//   SEL_WDATA=2'b01, SEL_RDATA=2'b10; SEL_NEXT function (10->00 wrap).
// - Sub-module btn_debounce (synchroniser + counter, param DEB_CYCLES, out level + rise pulse).
// - Top: FSM, capture registers, counter, proto_err, select register.
// TESTING (bench overrides DEB_CYCLES=8)
// - Write paddr=0x0000_1234 pwdata=0xCAFE_0001, 0 wait -> address=0x1234, data=0xCAFE0001,
//   coming_data=0, xfer_count=1, one cycle after completion.
// - Read paddr=0x20 prdata=0xBEEF, 3 wait states with prdata=0x1111 before pready -> coming_data=0xBEEF,
//   data unchanged, xfer_count=2.
// - btn bounces 1/0 in 3-cycle pulses then holds 1 for 20 cycles -> switch 00->01 exactly once;
//   three clean presses from 01 -> 10, 00, 01.
// - penable=1 with psel=1 from IDLE (no SETUP) -> proto_err=1 sticky, no capture, count unchanged.
// - rst_n pulsed low during ACCESS with pready=0 -> all outputs 0 immediately; following full write
//   captured normally.
// - DISP_FREEZE_EN build: freeze=1, write 0x55 to 0x40 -> address/data unchanged, xfer_count+1;
//   freeze=0, write 0x66 to 0x44 -> address=0x44, data=0x66.

Source files
------------

// File: rtl/apb_display_capture_pkg.sv
// Shared types for the APB display capture block: bus-phase state encoding,
// display select codes and the select sequencing helper.
package apb_disp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic [1:0] SEL_ADDR  = 2'b00;
  localparam logic [1:0] SEL_WDATA = 2'b01;
  localparam logic [1:0] SEL_RDATA = 2'b10;

  // Cycles addr -> wdata -> rdata -> addr; the unused code 11 recovers to addr.
  function automatic logic [1:0] SEL_NEXT(input logic [1:0] sel);
    case (sel)
      SEL_ADDR:  SEL_NEXT = SEL_WDATA;
      SEL_WDATA: SEL_NEXT = SEL_RDATA;
      default:   SEL_NEXT = SEL_ADDR;
    endcase
  endfunction

endpackage

// File: rtl/apb_display_capture_if.sv
// APB pin bundle. The capture block only observes the bus, so it uses the
// all-input monitor modport; master/slave describe the real bus agents.
interface apb_display_capture_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  modport master  (output psel, penable, pwrite, paddr, pwdata, input prdata, pready);
  modport slave   (input psel, penable, pwrite, paddr, pwdata, output prdata, pready);
  modport monitor (input psel, penable, pwrite, paddr, pwdata, prdata, pready);
endinterface

// File: rtl/apb_display_capture_btn_debounce.sv
// Front-panel button debouncer: 2-FF synchroniser, then a level must hold for
// DEB_CYCLES clocks before it is accepted. Emits accepted level and a rise pulse.
module btn_debounce #(
  parameter int DEB_CYCLES = 400000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;

  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_inc = cnt_q + 1'b1;
    // Any return to the accepted level restarts the qualification window.
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_inc == DEB_MAX) begin
      cnt_d   = '0;
      level_d = ~level_q;
      rise_d  = ~level_q;
    end else begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
endmodule

// File: rtl/apb_display_capture.sv
// Passive APB monitor feeding the seven-segment display: captures the last completed
// transfer, counts completions, flags protocol errors. Optional DISP_FREEZE_EN freezes capture.
module apb_display_capture
  import apb_disp_pkg::*;
#(
  parameter int DEB_CYCLES = 400000,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  apb_display_capture_if.monitor    apb,
  input  logic                      btn,
  input  logic                      freeze,
  output logic [31:0]               address,
  output logic [31:0]               data,
  output logic [31:0]               coming_data,
  output logic [1:0]                switch,
  output logic [CNT_W-1:0]          xfer_count,
  output logic                      proto_err
);

  apb_state_e       state_q, state_d;
  logic [31:0]      address_q, address_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      coming_data_q, coming_data_d;
  logic [1:0]       switch_q, switch_d;
  logic [CNT_W-1:0] xfer_count_q, xfer_count_d;
  logic             proto_err_q, proto_err_d;
  logic             complete;
  logic             cap_en;
  logic             btn_rise;
  logic             btn_level_unused;

`ifdef DISP_FREEZE_EN
  assign cap_en = ~freeze;
`else
  logic unused_freeze;
  assign unused_freeze = freeze;
  assign cap_en        = 1'b1;
`endif

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .level (btn_level_unused),
    .rise  (btn_rise)
  );

  // state_q names the phase of the previous bus cycle: after SETUP (or a
  // waited ACCESS) the current cycle is an access cycle and may complete.
  always_comb begin
    state_d       = state_q;
    proto_err_d   = proto_err_q;
    complete      = 1'b0;
    address_d     = address_q;
    data_d        = data_q;
    coming_data_d = coming_data_q;
    xfer_count_d  = xfer_count_q;
    switch_d      = switch_q;

    case (state_q)
      IDLE: begin
        if (apb.penable) begin
          proto_err_d = 1'b1;
        end else if (apb.psel) begin
          state_d = SETUP;
        end
      end
      SETUP, ACCESS: begin
        if (!apb.psel || !apb.penable) begin
          proto_err_d = 1'b1;
          state_d     = IDLE;
        end else if (apb.pready) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d = ACCESS;
        end
      end
      default: state_d = IDLE;
    endcase

    if (complete) begin
      xfer_count_d = xfer_count_q + 1'b1;
      if (cap_en) begin
        address_d = apb.paddr;
        if (apb.pwrite) data_d = apb.pwdata;
        else            coming_data_d = apb.prdata;
      end
    end

    if (btn_rise) switch_d = SEL_NEXT(switch_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      address_q     <= '0;
      data_q        <= '0;
      coming_data_q <= '0;
      switch_q      <= SEL_ADDR;
      xfer_count_q  <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      address_q     <= address_d;
      data_q        <= data_d;
      coming_data_q <= coming_data_d;
      switch_q      <= switch_d;
      xfer_count_q  <= xfer_count_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign address     = address_q;
  assign data        = data_q;
  assign coming_data = coming_data_q;
  assign switch      = switch_q;
  assign xfer_count  = xfer_count_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_apb_display_capture.sv
// Directed self-checking bench for apb_display_capture (DEB_CYCLES=8); covers
// capture, wait states, debounce, protocol errors, async reset and DISP_FREEZE_EN.
module tb_apb_display_capture;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             btn;
  logic             freeze;
  logic [31:0]      address;
  logic [31:0]      data;
  logic [31:0]      coming_data;
  logic [1:0]       switch;
  logic [CNT_W-1:0] xfer_count;
  logic             proto_err;

  int vectors;
  int miscompares;

  apb_display_capture_if bus ();

  apb_display_capture #(
    .DEB_CYCLES (8),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .apb         (bus),
    .btn         (btn),
    .freeze      (freeze),
    .address     (address),
    .data        (data),
    .coming_data (coming_data),
    .switch      (switch),
    .xfer_count  (xfer_count),
    .proto_err   (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_setup(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = wdata;
    bus.pready  = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_access(input logic ready, input logic [31:0] rdata);
    bus.penable = 1'b1;
    bus.pready  = ready;
    bus.prdata  = rdata;
    @(negedge clk);
    if (ready)
      $display("txn %s addr=%h wdata=%h rdata=%h", bus.pwrite ? "WR" : "RD",
               bus.paddr, bus.pwdata, bus.prdata);
  endtask

  task automatic bus_idle();
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pready  = 1'b0;
    @(negedge clk);
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] wdata);
    bus_setup(1'b1, addr, wdata);
    bus_access(1'b1, 32'h0);
  endtask

  task automatic hold_btn(input logic lvl, input int cycles);
    btn = lvl;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    btn         = 1'b0;
    freeze      = 1'b0;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pwdata  = '0;
    bus.prdata  = '0;
    bus.pready  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_address", address, 32'h0);
    chk("rst_data", data, 32'h0);
    chk("rst_coming", coming_data, 32'h0);
    chk("rst_switch", 32'(switch), 32'h0);
    chk("rst_count", 32'(xfer_count), 32'h0);
    chk("rst_err", 32'(proto_err), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait write; values visible one cycle after the completing cycle.
    bus_setup(1'b1, 32'h0000_1234, 32'hCAFE_0001);
    bus.penable = 1'b1;
    bus.pready  = 1'b1;
    #1 chk("wr_pre_capture", address, 32'h0);
    @(negedge clk);
    chk("wr_address", address, 32'h0000_1234);
    chk("wr_data", data, 32'hCAFE_0001);
    chk("wr_coming", coming_data, 32'h0);
    chk("wr_count", 32'(xfer_count), 32'd1);
    bus_idle();

    // Read with three wait states; stale prdata during waits must be ignored.
    bus_setup(1'b0, 32'h20, 32'hFFFF_FFFF);
    repeat (3) bus_access(1'b0, 32'h1111);
    chk("rd_wait_coming", coming_data, 32'h0);
    chk("rd_wait_address", address, 32'h0000_1234);
    chk("rd_wait_count", 32'(xfer_count), 32'd1);
    bus_access(1'b1, 32'hBEEF);
    chk("rd_coming", coming_data, 32'hBEEF);
    chk("rd_address", address, 32'h20);
    chk("rd_data_kept", data, 32'hCAFE_0001);
    chk("rd_count", 32'(xfer_count), 32'd2);
    bus_idle();

    // Bounces shorter than the debounce window, then a long press.
    for (int i = 0; i < 3; i++) begin
      hold_btn(1'b1, 3);
      hold_btn(1'b0, 3);
    end
    chk("bounce_switch", 32'(switch), 32'h0);
    hold_btn(1'b1, 20);
    chk("press1_switch", 32'(switch), 32'h1);
    hold_btn(1'b1, 20);
    chk("press1_held", 32'(switch), 32'h1);
    hold_btn(1'b0, 15);
    chk("release_switch", 32'(switch), 32'h1);
    hold_btn(1'b1, 15);
    hold_btn(1'b0, 15);
    chk("press2_switch", 32'(switch), 32'h2);
    hold_btn(1'b1, 15);
    hold_btn(1'b0, 15);
    chk("press3_switch", 32'(switch), 32'h0);
    hold_btn(1'b1, 15);
    hold_btn(1'b0, 15);
    chk("press4_switch", 32'(switch), 32'h1);

    // ENABLE without SETUP from idle.
    bus.psel    = 1'b1;
    bus.penable = 1'b1;
    bus.pwrite  = 1'b1;
    bus.paddr   = 32'h9999;
    bus.pwdata  = 32'h7777;
    bus.pready  = 1'b1;
    @(negedge clk);
    bus_idle();
    chk("err_flag", 32'(proto_err), 32'h1);
    chk("err_address", address, 32'h20);
    chk("err_data", data, 32'hCAFE_0001);
    chk("err_count", 32'(xfer_count), 32'd2);
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(proto_err), 32'h1);

    // Async reset while an access phase is stalled.
    bus_setup(1'b1, 32'h300, 32'hDEAD);
    bus_access(1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_address", address, 32'h0);
    chk("mid_rst_data", data, 32'h0);
    chk("mid_rst_coming", coming_data, 32'h0);
    chk("mid_rst_switch", 32'(switch), 32'h0);
    chk("mid_rst_count", 32'(xfer_count), 32'h0);
    chk("mid_rst_err", 32'(proto_err), 32'h0);
    bus_idle();
    rst_n = 1'b1;
    @(negedge clk);
    apb_write(32'h80, 32'h77);
    chk("post_rst_address", address, 32'h80);
    chk("post_rst_data", data, 32'h77);
    chk("post_rst_count", 32'(xfer_count), 32'd1);
    chk("post_rst_err", 32'(proto_err), 32'h0);
    bus_idle();

    // Freeze handling differs by build.
    freeze = 1'b1;
    apb_write(32'h40, 32'h55);
`ifdef DISP_FREEZE_EN
    chk("frz_address", address, 32'h80);
    chk("frz_data", data, 32'h77);
`else
    chk("nofrz_address", address, 32'h40);
    chk("nofrz_data", data, 32'h55);
`endif
    chk("frz_count", 32'(xfer_count), 32'd2);
    bus_idle();
    freeze = 1'b0;
    apb_write(32'h44, 32'h66);
    chk("unfrz_address", address, 32'h44);
    chk("unfrz_data", data, 32'h66);
    chk("unfrz_count", 32'(xfer_count), 32'd3);
    bus_idle();

    // psel dropped during a stalled access phase.
    bus_setup(1'b1, 32'hA0, 32'hABCD);
    bus_access(1'b0, 32'h0);
    bus_idle();
    chk("drop_err", 32'(proto_err), 32'h1);
    chk("drop_address", address, 32'h44);
    chk("drop_count", 32'(xfer_count), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
